// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP: state codes, instruction opcodes,
// IR width and data-register select encoding.
// Optional feature macro: JTAG_TAP_USERCODE_EN (enables the USERCODE register).
package jtag_pkg;

  localparam int IR_W = 4;

  // TAP controller state codes (IEEE 1149.1 encoding)
  typedef enum logic [3:0] {
    ST_EX2_DR = 4'h0,
    ST_EX1_DR = 4'h1,
    ST_SH_DR  = 4'h2,
    ST_PAU_DR = 4'h3,
    ST_SEL_IR = 4'h4,
    ST_UPD_DR = 4'h5,
    ST_CAP_DR = 4'h6,
    ST_SEL_DR = 4'h7,
    ST_EX2_IR = 4'h8,
    ST_EX1_IR = 4'h9,
    ST_SH_IR  = 4'hA,
    ST_PAU_IR = 4'hB,
    ST_RTI    = 4'hC,
    ST_UPD_IR = 4'hD,
    ST_CAP_IR = 4'hE,
    ST_TLR    = 4'hF
  } tap_state_e;

  // Instruction opcodes
  localparam logic [IR_W-1:0] OP_RUNBIST  = 4'h4;
  localparam logic [IR_W-1:0] OP_GETTEST  = 4'h5;
  localparam logic [IR_W-1:0] OP_IDCODE   = 4'h7;
  localparam logic [IR_W-1:0] OP_USERCODE = 4'h8;
  localparam logic [IR_W-1:0] OP_BYPASS   = 4'hF;

  // Value loaded into the IR shift register in Capture-IR
  localparam logic [IR_W-1:0] IR_CAPTURE  = 4'b0001;

  // Data register selected by the active instruction
  typedef enum logic [2:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_USERCODE,
    SEL_GETTEST,
    SEL_RUNBIST
  } dr_sel_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller state machine. tap_state is the current state code,
// tap_next the state that will be entered on the next rising TCK.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output logic [3:0] tap_state,
  output logic [3:0] tap_next
);

  tap_state_e state_q, state_d;

  // State register, asynchronously forced to Test-Logic-Reset
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) state_q <= ST_TLR;
    else       state_q <= state_d;
  end

  // Next-state logic: standard 1149.1 transition graph
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:    state_d = TMS ? ST_TLR    : ST_RTI;
      ST_RTI:    state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: state_d = TMS ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: state_d = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_d = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_d = TMS ? ST_UPD_DR : ST_PAU_DR;
      ST_PAU_DR: state_d = TMS ? ST_EX2_DR : ST_PAU_DR;
      ST_EX2_DR: state_d = TMS ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: state_d = TMS ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: state_d = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_d = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_d = TMS ? ST_UPD_IR : ST_PAU_IR;
      ST_PAU_IR: state_d = TMS ? ST_EX2_IR : ST_PAU_IR;
      ST_EX2_IR: state_d = TMS ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_d = TMS ? ST_SEL_DR : ST_RTI;
      default:   state_d = ST_TLR;
    endcase
  end

  // Outputs: expose current and next state codes
  always_comb begin
    tap_state = state_q;
    tap_next  = state_d;
  end

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP top: instruction register, instruction decode and data registers
// (BYPASS, IDCODE, GETTEST, RUNBIST, optional USERCODE).
// Optional feature macro: JTAG_TAP_USERCODE_EN. Without it opcode 4'h8 is BYPASS.
// Update side effects (ir, gt_data/gt_valid, bist_cfg/bist_start) take effect on
// the rising edge that enters Update-IR/Update-DR, so they are visible during it.
// The TLR force of ir likewise happens on the edge that enters Test-Logic-Reset.
module jtag_tap
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE_VAL   = 32'h1000_0ABD,
  parameter logic [31:0] USERCODE_VAL = 32'h0000_0001,
  parameter int          GT_W         = 10,
  parameter int          SIG_W        = 16
) (
  input  logic             TCK,
  input  logic             TRST,
  input  logic             TMS,
  input  logic             TDI,
  output logic             TDO,
  output logic             TDO_EN,
  output logic [3:0]       tap_state,
  output logic [IR_W-1:0]  ir,
  output logic [GT_W-1:0]  gt_data,
  output logic             gt_valid,
  output logic [SIG_W-1:0] bist_cfg,
  output logic             bist_start,
  input  logic [SIG_W-1:0] bist_sig
);

  logic [3:0] tap_next;
  tap_state_e cur_st, nxt_st;
  dr_sel_e    dr_sel;
  logic       dr_lsb;

  logic [IR_W-1:0]  ir_sr_q, ir_sr_d, ir_q, ir_d;
  logic             bypass_q, bypass_d;
  logic [31:0]      id_sr_q, id_sr_d;
  logic [GT_W-1:0]  gt_sr_q, gt_sr_d, gt_data_q, gt_data_d;
  logic [SIG_W-1:0] bist_sr_q, bist_sr_d, bist_cfg_q, bist_cfg_d;
  logic             gt_valid_q, gt_valid_d, bist_start_q, bist_start_d;
  logic             tdo_q, tdo_d;
`ifdef JTAG_TAP_USERCODE_EN
  logic [31:0]      uc_sr_q, uc_sr_d;
`else
  // USERCODE_VAL stays in the parameter list so both builds share one interface
  if (USERCODE_VAL[0] == 1'b0) begin : g_usercode_unused
  end
`endif

  jtag_tap_fsm u_fsm (
    .TCK       (TCK),
    .TRST      (TRST),
    .TMS       (TMS),
    .tap_state (tap_state),
    .tap_next  (tap_next)
  );

  assign cur_st = tap_state_e'(tap_state);
  assign nxt_st = tap_state_e'(tap_next);

  // Instruction decode: unknown opcodes fall back to BYPASS
  always_comb begin
    dr_sel = SEL_BYPASS;
    case (ir_q)
      OP_IDCODE:   dr_sel = SEL_IDCODE;
`ifdef JTAG_TAP_USERCODE_EN
      OP_USERCODE: dr_sel = SEL_USERCODE;
`endif
      OP_GETTEST:  dr_sel = SEL_GETTEST;
      OP_RUNBIST:  dr_sel = SEL_RUNBIST;
      default:     dr_sel = SEL_BYPASS;
    endcase
  end

  // IR shift register and active instruction
  always_comb begin
    ir_sr_d = ir_sr_q;
    ir_d    = ir_q;
    if (cur_st == ST_CAP_IR)     ir_sr_d = IR_CAPTURE;
    else if (cur_st == ST_SH_IR) ir_sr_d = {TDI, ir_sr_q[IR_W-1:1]};
    if (nxt_st == ST_TLR)         ir_d = OP_IDCODE;
    else if (nxt_st == ST_UPD_IR) ir_d = ir_sr_q;
  end

  // Data shift registers: capture and right-shift only the selected one
  always_comb begin
    bypass_d  = bypass_q;
    id_sr_d   = id_sr_q;
    gt_sr_d   = gt_sr_q;
    bist_sr_d = bist_sr_q;
`ifdef JTAG_TAP_USERCODE_EN
    uc_sr_d   = uc_sr_q;
`endif
    if (cur_st == ST_CAP_DR) begin
      case (dr_sel)
        SEL_IDCODE:   id_sr_d   = IDCODE_VAL;
`ifdef JTAG_TAP_USERCODE_EN
        SEL_USERCODE: uc_sr_d   = USERCODE_VAL;
`endif
        SEL_GETTEST:  gt_sr_d   = gt_data_q;
        SEL_RUNBIST:  bist_sr_d = bist_sig;
        default:      bypass_d  = 1'b0;
      endcase
    end else if (cur_st == ST_SH_DR) begin
      case (dr_sel)
        SEL_IDCODE:   id_sr_d   = {TDI, id_sr_q[31:1]};
`ifdef JTAG_TAP_USERCODE_EN
        SEL_USERCODE: uc_sr_d   = {TDI, uc_sr_q[31:1]};
`endif
        SEL_GETTEST:  gt_sr_d   = {TDI, gt_sr_q[GT_W-1:1]};
        SEL_RUNBIST:  bist_sr_d = {TDI, bist_sr_q[SIG_W-1:1]};
        default:      bypass_d  = TDI;
      endcase
    end
  end

  // Update-DR side effects with single-cycle strobes
  always_comb begin
    gt_data_d    = gt_data_q;
    gt_valid_d   = 1'b0;
    bist_cfg_d   = bist_cfg_q;
    bist_start_d = 1'b0;
    if (nxt_st == ST_UPD_DR && dr_sel == SEL_GETTEST) begin
      gt_data_d  = gt_sr_q;
      gt_valid_d = 1'b1;
    end
    if (nxt_st == ST_UPD_DR && dr_sel == SEL_RUNBIST) begin
      bist_cfg_d   = bist_sr_q;
      bist_start_d = 1'b1;
    end
  end

  // Serial output: LSB of the register being shifted, 0 outside shift states
  always_comb begin
    case (dr_sel)
      SEL_IDCODE:   dr_lsb = id_sr_q[0];
`ifdef JTAG_TAP_USERCODE_EN
      SEL_USERCODE: dr_lsb = uc_sr_q[0];
`endif
      SEL_GETTEST:  dr_lsb = gt_sr_q[0];
      SEL_RUNBIST:  dr_lsb = bist_sr_q[0];
      default:      dr_lsb = bypass_q;
    endcase
    tdo_d = 1'b0;
    if (cur_st == ST_SH_IR)      tdo_d = ir_sr_q[0];
    else if (cur_st == ST_SH_DR) tdo_d = dr_lsb;
  end

  // Rising-edge state for IR and data registers
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_sr_q      <= '0;
      ir_q         <= OP_IDCODE;
      bypass_q     <= 1'b0;
      id_sr_q      <= '0;
      gt_sr_q      <= '0;
      bist_sr_q    <= '0;
      gt_data_q    <= '0;
      gt_valid_q   <= 1'b0;
      bist_cfg_q   <= '0;
      bist_start_q <= 1'b0;
`ifdef JTAG_TAP_USERCODE_EN
      uc_sr_q      <= '0;
`endif
    end else begin
      ir_sr_q      <= ir_sr_d;
      ir_q         <= ir_d;
      bypass_q     <= bypass_d;
      id_sr_q      <= id_sr_d;
      gt_sr_q      <= gt_sr_d;
      bist_sr_q    <= bist_sr_d;
      gt_data_q    <= gt_data_d;
      gt_valid_q   <= gt_valid_d;
      bist_cfg_q   <= bist_cfg_d;
      bist_start_q <= bist_start_d;
`ifdef JTAG_TAP_USERCODE_EN
      uc_sr_q      <= uc_sr_d;
`endif
    end
  end

  // TDO launched on the falling edge so it is stable at the next rising edge
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) tdo_q <= 1'b0;
    else       tdo_q <= tdo_d;
  end

  assign TDO        = tdo_q;
  assign TDO_EN     = (cur_st == ST_SH_IR) || (cur_st == ST_SH_DR);
  assign ir         = ir_q;
  assign gt_data    = gt_data_q;
  assign gt_valid   = gt_valid_q;
  assign bist_cfg   = bist_cfg_q;
  assign bist_start = bist_start_q;

endmodule

// File: tb/tb_jtag_tap.sv
// Self-checking bench for jtag_tap: table-driven TAP state walk plus
// hand-written IR/DR scan sequences. Inputs change at falling TCK + 1.
module tb_jtag_tap;

  localparam logic [31:0] IDV   = 32'h1000_0ABD;
  localparam logic [31:0] UCV   = 32'h0000_0001;
  localparam int          GT_W  = 10;
  localparam int          SIG_W = 16;

  logic             TCK = 1'b0;
  logic             TRST = 1'b0;
  logic             TMS = 1'b1;
  logic             TDI = 1'b0;
  logic             TDO, TDO_EN;
  logic [3:0]       tap_state;
  logic [3:0]       ir;
  logic [GT_W-1:0]  gt_data;
  logic             gt_valid;
  logic [SIG_W-1:0] bist_cfg;
  logic             bist_start;
  logic [SIG_W-1:0] bist_sig = '0;

  jtag_tap #(
    .IDCODE_VAL   (IDV),
    .USERCODE_VAL (UCV),
    .GT_W         (GT_W),
    .SIG_W        (SIG_W)
  ) dut (
    .TCK        (TCK),
    .TRST       (TRST),
    .TMS        (TMS),
    .TDI        (TDI),
    .TDO        (TDO),
    .TDO_EN     (TDO_EN),
    .tap_state  (tap_state),
    .ir         (ir),
    .gt_data    (gt_data),
    .gt_valid   (gt_valid),
    .bist_cfg   (bist_cfg),
    .bist_start (bist_start),
    .bist_sig   (bist_sig)
  );

  // Clock
  always #5 TCK = ~TCK;

  // Pulse counters (cycles high, sampled mid-cycle)
  int gt_pulses = 0;
  int bs_pulses = 0;
  always @(negedge TCK) begin
    if (gt_valid)   gt_pulses++;
    if (bist_start) bs_pulses++;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;
  logic upd_gt, upd_bs;
  logic [3:0] upd_state;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One TCK cycle: sample TDO of the current state, then apply TMS/TDI for the rising edge
  task automatic tick(input logic tms, input logic tdi, output logic tdo_s);
    @(negedge TCK);
    #1;
    tdo_s = TDO;
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  task automatic do_reset();
    logic d;
    @(negedge TCK); #1;
    TRST = 1'b0; TMS = 1'b1; TDI = 1'b0;
    @(negedge TCK); #1;
    TRST = 1'b1;
    tick(1'b0, 1'b0, d);  // TLR -> RTI
  endtask

  // IR scan from RTI back to RTI
  task automatic ir_scan(input logic [3:0] v, output logic [3:0] dout);
    logic d;
    tick(1'b1, 1'b0, d);
    tick(1'b1, 1'b0, d);
    tick(1'b0, 1'b0, d);
    tick(1'b0, 1'b0, d);
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, v[i], d);
      dout[i] = d;
    end
    tick(1'b1, 1'b0, d);
    tick(1'b0, 1'b0, d);
  endtask

  // DR scan of n bits from RTI back to RTI, recording strobes seen in Update-DR
  task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout);
    logic d;
    dout = '0;
    tick(1'b1, 1'b0, d);
    tick(1'b0, 1'b0, d);
    tick(1'b0, 1'b0, d);
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i], d);
      dout[i] = d;
    end
    tick(1'b1, 1'b0, d);
    upd_gt    = gt_valid;
    upd_bs    = bist_start;
    upd_state = tap_state;
    tick(1'b0, 1'b0, d);
  endtask

  typedef struct {
    logic       tms;
    logic [3:0] exp_state;
    logic       exp_en;
  } walk_t;

  walk_t walk[24];

  initial begin
    logic [3:0]  iro;
    logic [63:0] dro;
    logic        d;
    int          gp, bp;

    walk = '{
      '{1'b0, 4'hC, 1'b0}, '{1'b0, 4'hC, 1'b0}, '{1'b1, 4'h7, 1'b0}, '{1'b0, 4'h6, 1'b0},
      '{1'b0, 4'h2, 1'b1}, '{1'b1, 4'h1, 1'b0}, '{1'b0, 4'h3, 1'b0}, '{1'b1, 4'h0, 1'b0},
      '{1'b0, 4'h2, 1'b1}, '{1'b1, 4'h1, 1'b0}, '{1'b1, 4'h5, 1'b0}, '{1'b1, 4'h7, 1'b0},
      '{1'b1, 4'h4, 1'b0}, '{1'b0, 4'hE, 1'b0}, '{1'b0, 4'hA, 1'b1}, '{1'b1, 4'h9, 1'b0},
      '{1'b0, 4'hB, 1'b0}, '{1'b1, 4'h8, 1'b0}, '{1'b0, 4'hA, 1'b1}, '{1'b1, 4'h9, 1'b0},
      '{1'b1, 4'hD, 1'b0}, '{1'b1, 4'h7, 1'b0}, '{1'b1, 4'h4, 1'b0}, '{1'b1, 4'hF, 1'b0}
    };

    // Reset values while TRST is held low
    #12;
    check("rst_state",      64'(tap_state),  64'hF);
    check("rst_ir",         64'(ir),         64'h7);
    check("rst_gt_data",    64'(gt_data),    64'h0);
    check("rst_gt_valid",   64'(gt_valid),   64'h0);
    check("rst_bist_cfg",   64'(bist_cfg),   64'h0);
    check("rst_bist_start", 64'(bist_start), 64'h0);
    check("rst_tdo",        64'(TDO),        64'h0);
    check("rst_tdo_en",     64'(TDO_EN),     64'h0);
    @(negedge TCK); #1;
    TRST = 1'b1;

    // Table-driven walk through every TAP state starting from TLR
    for (int i = 0; i < 24; i++) begin
      tick(walk[i].tms, 1'b0, d);
      check($sformatf("walk%0d_state", i), 64'(tap_state), 64'(walk[i].exp_state));
      check($sformatf("walk%0d_en", i),    64'(TDO_EN),    64'(walk[i].exp_en));
    end
    check("walk_ir_tlr", 64'(ir), 64'h7);

    // IDCODE read after reset
    do_reset();
    dr_scan(32, 64'h0, dro);
    check("idcode_word", dro[31:0], 64'(IDV));
    check("idcode_bit0", 64'(dro[0]), 64'h1);

    // GETTEST write, then read back and overwrite
    ir_scan(4'h5, iro);
    check("ir_capture_gt", 64'(iro), 64'h1);
    check("ir_gettest",    64'(ir),  64'h5);
    gp = gt_pulses;
    dr_scan(10, 64'h3DA, dro);
    check("gt_capture0",   dro[9:0],          64'h0);
    check("gt_data_3da",   64'(gt_data),      64'h3DA);
    check("gt_valid_upd",  64'(upd_gt),       64'h1);
    check("gt_upd_state",  64'(upd_state),    64'h5);
    check("gt_pulse_cnt",  64'(gt_pulses-gp), 64'h1);
    check("gt_valid_low",  64'(gt_valid),     64'h0);
    dr_scan(10, 64'h155, dro);
    check("gt_readback",   dro[9:0],          64'h3DA);
    check("gt_data_155",   64'(gt_data),      64'h155);
    // 13-bit shift: only the last 10 bits (13'h15A5 >> 3 = 10'h2B4) remain
    dr_scan(13, 64'h15A5, dro);
    check("gt_long_tdo",   dro[9:0],          64'h155);
    check("gt_long_data",  64'(gt_data),      64'h2B4);

    // RUNBIST: signature out, config in
    bist_sig = 16'hBEEF;
    ir_scan(4'h4, iro);
    check("ir_capture_rb", 64'(iro), 64'h1);
    gp = gt_pulses;
    bp = bs_pulses;
    dr_scan(16, 64'hAAAA, dro);
    check("bist_sig_tdo",   dro[15:0],         64'hBEEF);
    check("bist_cfg",       64'(bist_cfg),     64'hAAAA);
    check("bist_start_upd", 64'(upd_bs),       64'h1);
    check("bist_pulse_cnt", 64'(bs_pulses-bp), 64'h1);
    check("bist_no_gt",     64'(gt_pulses-gp), 64'h0);

    // Undefined opcode selects BYPASS: TDI 1,0,1,1 -> TDO 0,1,0,1
    ir_scan(4'h3, iro);
    check("ir_undef", 64'(ir), 64'h3);
    dr_scan(4, 64'hD, dro);
    check("bypass_tdo", dro[3:0], 64'hA);

    // Opcode 8: USERCODE when enabled, BYPASS otherwise
    ir_scan(4'h8, iro);
`ifdef JTAG_TAP_USERCODE_EN
    dr_scan(32, 64'h0, dro);
    check("usercode_word", dro[31:0], 64'(UCV));
`else
    dr_scan(4, 64'hD, dro);
    check("op8_bypass_tdo", dro[3:0], 64'hA);
`endif

    // Five TMS=1 edges from Shift-DR reach TLR with ir forced to IDCODE
    ir_scan(4'h5, iro);
    tick(1'b1, 1'b0, d);
    tick(1'b0, 1'b0, d);
    tick(1'b0, 1'b0, d);
    check("shdr_state", 64'(tap_state), 64'h2);
    check("shdr_en",    64'(TDO_EN),    64'h1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, d);
    check("tms5_state", 64'(tap_state), 64'hF);
    check("tms5_ir",    64'(ir),        64'h7);

    // TRST mid GETTEST shift aborts with no update
    do_reset();
    ir_scan(4'h5, iro);
    gp = gt_pulses;
    tick(1'b1, 1'b0, d);
    tick(1'b0, 1'b0, d);
    tick(1'b0, 1'b0, d);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, d);
    @(negedge TCK); #1;
    TRST = 1'b0;
    #2;
    check("abort_state",   64'(tap_state), 64'hF);
    check("abort_gt_data", 64'(gt_data),   64'h0);
    check("abort_ir",      64'(ir),        64'h7);
    check("abort_tdo",     64'(TDO),       64'h0);
    check("abort_tdo_en",  64'(TDO_EN),    64'h0);
    TMS = 1'b1;
    repeat (2) @(posedge TCK);
    @(negedge TCK); #1;
    TRST = 1'b1;
    repeat (2) @(posedge TCK);
    #1;
    check("abort_no_gt_valid", 64'(gt_pulses-gp), 64'h0);
    check("abort_gt_held",     64'(gt_data),      64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
